// File: rtl/doodle_jump_physics.sv
// doodle_jump_physics: per-frame doodle motion (gravity, jump, buttons) with a sequential platform landing scan.
// Ports: clk, rst (sync, active-high); btn_left/btn_right level inputs; platforms[i] = {left x, top y} with
// platform_activation[i]; outputs doodle_x, doodle_y, ground (last landed {left, top}), ground_valid pulse,
// sticky game_over, busy during MOVE/SCAN/COMMIT. Define DOODLE_HWRAP_EN for horizontal wrap instead of clamp.
module doodle_jump_physics #(
  parameter int CLK      = 50000000,
  parameter int FPS      = 50,
  parameter int N_PLAT   = 93,
  parameter int DOODLE_W = 61,
  parameter int DOODLE_H = 80,
  parameter int PLAT_W   = 100,
  parameter int JUMP_V   = 16,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 16,
  parameter int X_STEP   = 4,
  parameter int X_MIN    = 342,
  parameter int X_MAX    = 670,
  parameter int SCREEN_H = 768,
  parameter int X0       = 456,
  parameter int Y0       = 400
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              btn_left,
  input  logic                              btn_right,
  input  logic signed [N_PLAT-1:0][1:0][10:0] platforms,
  input  logic [N_PLAT-1:0]                 platform_activation,
  output logic [10:0]                       doodle_x,
  output logic [9:0]                        doodle_y,
  output logic [1:0][9:0]                   ground,
  output logic                              ground_valid,
  output logic                              game_over,
  output logic                              busy
);
  typedef enum logic [2:0] {IDLE, MOVE, SCAN, COMMIT, OVER} state_t;
  localparam int DIV = CLK / FPS;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = N_PLAT > 1 ? $clog2(N_PLAT) : 1;
  localparam logic signed [8:0] MF = 9'(MAX_FALL);
  localparam logic signed [8:0] GR = 9'(GRAVITY);
  localparam logic signed [7:0] JV = 8'(JUMP_V);
  localparam logic signed [11:0] DH = 12'(DOODLE_H);
  localparam logic signed [11:0] DW = 12'(DOODLE_W);
  localparam logic signed [11:0] PW = 12'(PLAT_W);
  localparam logic signed [11:0] SH = 12'(SCREEN_H);
  localparam logic signed [11:0] XS = 12'(X_STEP);
  localparam logic signed [11:0] LO = 12'(X_MIN);
  localparam logic signed [11:0] HI = 12'(X_MAX - DOODLE_W);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic tick, hit, hit_now;
  logic signed [7:0] vy, vy_n, vm, v_move;
  logic signed [8:0] vs;
  logic signed [11:0] yc, ym, y_move, y_n, xc, xm, x_move, x_n, top, left, best_top;
  logic [9:0] best_left;
  assign tick = cnt == CW'(DIV - 1);
  assign busy = state inside {MOVE, SCAN, COMMIT};
  always_comb begin
    vs = {vy[7], vy} + GR;
    vm = vs > MF ? MF[7:0] : vs[7:0];
    yc = {2'b0, doodle_y};
    ym = yc + {{4{vm[7]}}, vm};
    y_move = ym < 0 ? '0 : ym;
    v_move = ym < 0 ? '0 : vm;
    xc = {1'b0, doodle_x};
    xm = (btn_left && !btn_right) ? xc - XS : (btn_right && !btn_left) ? xc + XS : xc;
`ifdef DOODLE_HWRAP_EN
    x_move = xm < LO ? HI : xm > HI ? LO : xm;
`else
    x_move = xm < LO ? LO : xm > HI ? HI : xm;
`endif
    top = {platforms[idx][0][10], platforms[idx][0]};
    left = {platforms[idx][1][10], platforms[idx][1]};
    hit_now = platform_activation[idx] && vy_n > 0 && yc + DH <= top && top <= y_n + DH &&
              x_n + DW > left && x_n < left + PW;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      vy <= '0;
      vy_n <= '0;
      y_n <= '0;
      x_n <= '0;
      hit <= 1'b0;
      best_top <= '0;
      best_left <= '0;
      doodle_x <= 11'(X0);
      doodle_y <= 10'(Y0);
      ground <= '0;
      ground_valid <= 1'b0;
      game_over <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      ground_valid <= 1'b0;
      case (state)
        IDLE: state <= tick ? MOVE : IDLE;
        MOVE: begin
          vy_n <= v_move;
          y_n <= y_move;
          x_n <= x_move;
          hit <= 1'b0;
          idx <= '0;
          state <= SCAN;
        end
        SCAN: begin
          // strict < keeps the lowest index on equal tops
          if (hit_now && (!hit || top < best_top)) begin
            hit <= 1'b1;
            best_top <= top;
            best_left <= left[9:0];
          end
          idx <= idx + 1'b1;
          state <= idx == IW'(N_PLAT - 1) ? COMMIT : SCAN;
        end
        COMMIT: begin
          doodle_x <= x_n[10:0];
          state <= IDLE;
          if (hit) begin
            doodle_y <= 10'(best_top - DH);
            vy <= -JV;
            ground <= {best_left, best_top[9:0]};
            ground_valid <= 1'b1;
          end else if (y_n + DH >= SH) begin
            game_over <= 1'b1;
            state <= OVER;
          end else begin
            doodle_y <= y_n[9:0];
            vy <= vy_n;
          end
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_doodle_jump_physics.sv
// tb_doodle_jump_physics: directed checks of reset, falling, landing, priority, buttons, edges, fall-out and abort.
module tb_doodle_jump_physics;
  logic clk = 1'b0, rst = 1'b1, btn_left = 1'b0, btn_right = 1'b0;
  logic signed [92:0][1:0][10:0] plats = '0;
  logic [92:0] act = '0;
  logic [10:0] doodle_x;
  logic [9:0] doodle_y;
  logic [1:0][9:0] ground;
  logic ground_valid, game_over, busy;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  doodle_jump_physics #(.CLK(5000), .FPS(25)) dut (
    .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
    .platforms(plats), .platform_activation(act),
    .doodle_x(doodle_x), .doodle_y(doodle_y), .ground(ground),
    .ground_valid(ground_valid), .game_over(game_over), .busy(busy)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("start_timeout", busy, 1);
  endtask
  task automatic run_frame();
    int n = 0;
    wait_busy();
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("end_timeout", busy, 0);
  endtask
  task automatic run_frames(input int k);
    for (int i = 0; i < k; i++) run_frame();
  endtask
  initial begin
    int c, pulses;
    int ys[5] = '{401, 403, 406, 410, 415};
    @(negedge clk);
    do_reset();
    chk("rst_x", doodle_x, 456);
    chk("rst_y", doodle_y, 400);
    chk("rst_ground", ground, 0);
    chk("rst_gv", ground_valid, 0);
    chk("rst_over", game_over, 0);
    chk("rst_busy", busy, 0);
    plats[0][0] = 11'sd500;
    plats[0][1] = 11'sd456;
    act[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_frame();
      chk($sformatf("fall_y%0d", i + 1), doodle_y, ys[i]);
    end
    wait_busy();
    c = 0;
    while (!ground_valid && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("gv_latency", c, 95);
    chk("land_y", doodle_y, 420);
    chk("land_top", ground[0], 500);
    chk("land_left", ground[1], 456);
    @(negedge clk);
    chk("gv_width", ground_valid, 0);
    run_frame();
    chk("jump_y", doodle_y, 405);
    chk("ground_held", ground[0], 500);
    wait_busy();
    repeat (41) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_y", doodle_y, 400);
    chk("abort_x", doodle_x, 456);
    chk("abort_ground", ground, 0);
    chk("abort_busy", busy, 0);
    chk("abort_gv", ground_valid, 0);
    pulses = 0;
    repeat (150) begin
      @(negedge clk);
      pulses += ground_valid;
    end
    chk("abort_no_gv", pulses, 0);
    plats = '0;
    act = '0;
    plats[3][0] = 11'sd500; plats[3][1] = 11'sd400; act[3] = 1'b1;
    plats[5][0] = 11'sd498; plats[5][1] = 11'sd430; act[5] = 1'b1;
    plats[7][0] = 11'sd500; plats[7][1] = 11'sd480; act[7] = 1'b1;
    plats[10][0] = 11'sd496; plats[10][1] = 11'sd456;
    plats[20][0] = 11'sd497; plats[20][1] = 11'sd600; act[20] = 1'b1;
    do_reset();
    run_frames(6);
    chk("prio_top", ground[0], 498);
    chk("prio_left", ground[1], 430);
    chk("prio_y", doodle_y, 418);
    act[5] = 1'b0;
    do_reset();
    run_frames(6);
    chk("tie_top", ground[0], 500);
    chk("tie_left", ground[1], 400);
    act = '0;
    do_reset();
    btn_left = 1'b1;
    btn_right = 1'b1;
    run_frames(3);
    chk("both_x", doodle_x, 456);
    btn_right = 1'b0;
    run_frames(5);
    chk("left5_x", doodle_x, 436);
    btn_left = 1'b0;
    plats = '0;
    for (int i = 0; i < 5; i++) begin
      plats[i][0] = 11'sd500;
      plats[i][1] = 11'(300 + 80 * i);
      act[i] = 1'b1;
    end
    do_reset();
    btn_left = 1'b1;
    run_frames(29);
`ifdef DOODLE_HWRAP_EN
    chk("edge_l29", doodle_x, 609);
`else
    chk("edge_l29", doodle_x, 342);
`endif
    btn_left = 1'b0;
    btn_right = 1'b1;
    run_frame();
`ifdef DOODLE_HWRAP_EN
    chk("edge_r1", doodle_x, 342);
`else
    chk("edge_r1", doodle_x, 346);
`endif
    btn_right = 1'b0;
    btn_left = 1'b1;
    run_frame();
`ifdef DOODLE_HWRAP_EN
    chk("edge_l1", doodle_x, 609);
`else
    chk("edge_l1", doodle_x, 342);
`endif
    btn_left = 1'b0;
    btn_right = 1'b1;
    run_frames(68);
`ifdef DOODLE_HWRAP_EN
    chk("edge_r68", doodle_x, 342);
`else
    chk("edge_r68", doodle_x, 609);
`endif
    btn_right = 1'b0;
    chk("bounce_alive", game_over, 0);
    act = '0;
    do_reset();
    run_frames(16);
    chk("fall16_y", doodle_y, 536);
    run_frames(9);
    chk("fall25_y", doodle_y, 680);
    chk("fall25_over", game_over, 0);
    run_frame();
    chk("over_set", game_over, 1);
    chk("over_y", doodle_y, 680);
    chk("over_busy", busy, 0);
    c = 0;
    repeat (450) begin
      @(negedge clk);
      c += busy;
    end
    chk("over_ticks_ignored", c, 0);
    chk("over_frozen_y", doodle_y, 680);
    chk("over_sticky", game_over, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
